wdt_apb_arb: RTL and testbench

Two-port APB arbiter that shares the watchdog register interface between two bus masters, for example the system CPU and a debug/boot sequencer. It accepts an APB slave port from each master and replays the granted master's transfer on a single downstream APB master port wired to the watchdog bus-interface unit. Grants are round-robin. A bounded access timeout guarantees that neither master is blocked indefinitely.

---
 rtl/wdt_apb_arb_pkg.sv | 20 ++
 rtl/wdt_apb_arb_if.sv | 29 ++
 rtl/wdt_rr_arb2.sv | 33 +++
 rtl/wdt_apb_arb.sv | 133 +++++++++++++
 tb/tb_wdt_apb_arb.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wdt_apb_arb_pkg.sv
// Shared types and constants for the two-master watchdog APB arbiter.
package wdt_apb_arb_pkg;

  // Downstream transfer phases.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Width of the ACCESS-phase timeout counter.
  localparam int TO_W   = 8;

  // APB data width used on every port.
  localparam int DATA_W = 32;

  // Index of an upstream master (0 or 1).
  typedef logic mst_t;

endpackage

// File: rtl/wdt_apb_arb_if.sv
// APB signal bundle. The arbiter takes two slave-side bundles (one per
// upstream master) and drives one master-side bundle toward the watchdog BIU.
interface wdt_apb_arb_if #(
  parameter int ADDR_LHS = 10
);
  import wdt_apb_arb_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_LHS:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  // Issuer of transfers; the downstream BIU reports no error of its own.
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  // Responder to an upstream master.
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/wdt_rr_arb2.sv
// Two-request round-robin arbiter. On a tie the master not granted last wins;
// the grant history only moves when the caller commits a grant with upd.
module wdt_rr_arb2
  import wdt_apb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output mst_t       gnt,
  output mst_t       last_grant
);

  // Pick the winner from the current requests and the grant history.
  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

  // Remember who was granted; resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (upd) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/wdt_apb_arb.sv
// Shares the watchdog APB register interface between two upstream masters.
// The granted master's transfer is replayed downstream; a bounded ACCESS
// timeout turns a stuck slave into an error completion.
module wdt_apb_arb
  import wdt_apb_arb_pkg::*;
#(
  parameter int ADDR_LHS  = 10,
  parameter int TO_CYCLES = 16
) (
  input  logic          pclk,
  input  logic          preset,
  wdt_apb_arb_if.slave  s0,
  wdt_apb_arb_if.slave  s1,
  wdt_apb_arb_if.master m
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [TO_W-1:0]   cnt;
  logic [1:0]        req;
  logic [1:0]        done;
  logic              in_access;
  logic              complete;
  logic              load;
  mst_t              gnt;
  mst_t              owner;
  logic [ADDR_LHS:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;

  // A transfer completes on slave ready or when the timeout expires. Reset
  // abandons an in-flight transfer without any upstream response.
  assign in_access = (state == ACCESS);
  assign complete  = in_access && !preset && (m.pready || (cnt == TO_LAST));

  // The arbiter's grant history doubles as the current owner: it is updated
  // exactly when a transfer is granted and held until the next grant.
  assign done[0] = complete && (owner == 1'b0);
  assign done[1] = complete && (owner == 1'b1);

  // A master still holding psel in its completion cycle is not a new request.
  assign req = {s1.psel & ~done[1], s0.psel & ~done[0]};

  wdt_rr_arb2 u_arb (
    .clk        (pclk),
    .rst        (preset),
    .req        (req),
    .upd        (load),
    .gnt        (gnt),
    .last_grant (owner)
  );

  // Next phase; a new grant is taken from IDLE or straight out of a completion.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = SETUP;
          load      = 1'b1;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (complete) begin
          if (|req) begin
            state_nxt = SETUP;
            load      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Phase register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timeout counter: cleared while entering ACCESS, counts not-ready cycles.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= '0;
    end else if (in_access && !m.pready) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture the winner's request at grant time; held until the next grant.
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else if (load) begin
      paddr_q  <= gnt ? s1.paddr  : s0.paddr;
      pwdata_q <= gnt ? s1.pwdata : s0.pwdata;
      pwrite_q <= gnt ? s1.pwrite : s0.pwrite;
    end
  end

  assign m.psel    = (state != IDLE);
  assign m.penable = in_access;
  assign m.paddr   = paddr_q;
  assign m.pwdata  = pwdata_q;
  assign m.pwrite  = pwrite_q;

  // Read data passes straight through; the BIU already registers it.
  assign s0.pready  = done[0];
  assign s0.pslverr = done[0] & ~m.pready;
  assign s0.prdata  = (done[0] & m.pready) ? m.prdata : '0;

  assign s1.pready  = done[1];
  assign s1.pslverr = done[1] & ~m.pready;
  assign s1.prdata  = (done[1] & m.pready) ? m.prdata : '0;

endmodule

// File: tb/tb_wdt_apb_arb.sv
// Bench for wdt_apb_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transfer-level model.
`timescale 1ns/1ps
module tb_wdt_apb_arb;

  localparam int ADDR_LHS  = 10;
  localparam int TO_CYCLES = 16;
  localparam int AW        = ADDR_LHS + 1;

  logic          pclk   = 1'b0;
  logic          preset = 1'b1;

  logic          psel [2];
  logic          pen  [2];
  logic          pwr  [2];
  logic [AW-1:0] padr [2];
  logic [31:0]   pwd  [2];
  logic          mrdy = 1'b1;
  logic [31:0]   mrd  = '0;

  logic          up_rdy [2];
  logic          up_err [2];
  logic [31:0]   up_rd  [2];

  wdt_apb_arb_if #(.ADDR_LHS(ADDR_LHS)) s0_bus ();
  wdt_apb_arb_if #(.ADDR_LHS(ADDR_LHS)) s1_bus ();
  wdt_apb_arb_if #(.ADDR_LHS(ADDR_LHS)) m_bus ();

  wdt_apb_arb #(.ADDR_LHS(ADDR_LHS), .TO_CYCLES(TO_CYCLES)) dut (
    .pclk   (pclk),
    .preset (preset),
    .s0     (s0_bus),
    .s1     (s1_bus),
    .m      (m_bus)
  );

  always #5 pclk = ~pclk;

  assign s0_bus.psel    = psel[0];
  assign s0_bus.penable = pen[0];
  assign s0_bus.pwrite  = pwr[0];
  assign s0_bus.paddr   = padr[0];
  assign s0_bus.pwdata  = pwd[0];
  assign s1_bus.psel    = psel[1];
  assign s1_bus.penable = pen[1];
  assign s1_bus.pwrite  = pwr[1];
  assign s1_bus.paddr   = padr[1];
  assign s1_bus.pwdata  = pwd[1];
  assign m_bus.prdata   = mrd;
  assign m_bus.pready   = mrdy;
  assign m_bus.pslverr  = 1'b0;

  assign up_rdy[0] = s0_bus.pready;
  assign up_err[0] = s0_bus.pslverr;
  assign up_rd[0]  = s0_bus.prdata;
  assign up_rdy[1] = s1_bus.pready;
  assign up_err[1] = s1_bus.pslverr;
  assign up_rd[1]  = s1_bus.prdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 0;

  // Transfer-level model: one outstanding downstream transfer at most.
  bit            busy = 0;
  int            pos  = 0;   // 0 = setup cycle, k>=1 = k-th access cycle
  int            own  = 0;
  int            last = 1;
  logic [AW-1:0] sa   = '0;
  logic [31:0]   sd   = '0;
  logic          sw   = 1'b0;
  int            done_q[$];

  // Values seen in the most recently sampled cycle.
  logic          s_psel, s_pen, s_wr;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wd;
  logic          s_rdy [2];
  logic          s_err [2];
  logic [31:0]   s_rd  [2];
  bit            seen_rdy [2];
  bit            was_reset = 0;

  // Random driver state and knobs.
  bit auto_drv = 0;
  int act [2];
  int stuck    = 0;
  int req_pct  = 40;
  int rdy_pct  = 70;
  bit stuck_en = 1;
  bit rst_en   = 1;
  bit wr_only  = 0;

  task automatic chk(string name, logic [63:0] actv, logic [63:0] expv);
    n_cmp++;
    if (actv !== expv) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, actv, expv);
    end
  endtask

  task automatic sample_cycle();
    bit fin;
    bit mine;
    bit r [2];
    int g;
    @(negedge pclk);
    cyc++;
    fin = busy && (pos >= 1) && (mrdy || (pos == TO_CYCLES)) && !preset;
    if (chk_on) begin
      chk("m_psel", m_bus.psel, busy);
      chk("m_penable", m_bus.penable, busy && (pos >= 1));
      if (busy) begin
        chk("m_paddr", m_bus.paddr, sa);
        chk("m_pwdata", m_bus.pwdata, sd);
        chk("m_pwrite", m_bus.pwrite, sw);
      end
      for (int i = 0; i < 2; i++) begin
        mine = fin && (own == i);
        chk($sformatf("s%0d_pready", i), up_rdy[i], mine);
        chk($sformatf("s%0d_pslverr", i), up_err[i], mine && !mrdy);
        chk($sformatf("s%0d_prdata", i), up_rd[i], (mine && mrdy) ? mrd : 32'h0);
      end
    end
    s_psel = m_bus.psel;
    s_pen  = m_bus.penable;
    s_wr   = m_bus.pwrite;
    s_addr = m_bus.paddr;
    s_wd   = m_bus.pwdata;
    for (int i = 0; i < 2; i++) begin
      s_rdy[i]    = up_rdy[i];
      s_err[i]    = up_err[i];
      s_rd[i]     = up_rd[i];
      seen_rdy[i] = (up_rdy[i] === 1'b1);
    end
    was_reset = preset;
    if (fin) done_q.push_back(own);
    // advance the model to the next cycle
    if (preset) begin
      busy = 0;
      pos  = 0;
      last = 1;
    end else if (!busy || fin) begin
      r[0] = psel[0] && !(fin && own == 0);
      r[1] = psel[1] && !(fin && own == 1);
      if (r[0] || r[1]) begin
        if (r[0] && r[1]) g = 1 - last;
        else              g = r[1] ? 1 : 0;
        busy = 1;
        pos  = 0;
        own  = g;
        last = g;
        sa   = padr[g];
        sd   = pwd[g];
        sw   = pwr[g];
      end else begin
        busy = 0;
      end
    end else begin
      pos++;
    end
  endtask

  task automatic drive_auto();
    for (int i = 0; i < 2; i++) begin
      if (was_reset) act[i] = 0;
      else if (act[i] == 2 && seen_rdy[i]) act[i] = 0;
      else if (act[i] == 1) act[i] = 2;
      if (act[i] == 0 && !was_reset && $urandom_range(99) < req_pct) begin
        act[i]  = 1;
        padr[i] = AW'($urandom);
        pwd[i]  = $urandom;
        pwr[i]  = wr_only ? 1'b1 : 1'($urandom_range(1));
      end
      psel[i] = (act[i] != 0);
      pen[i]  = (act[i] == 2);
    end
    if (stuck > 0) begin
      stuck--;
      mrdy = 1'b0;
    end else begin
      if (stuck_en && $urandom_range(99) < 3) stuck = $urandom_range(30);
      mrdy = ($urandom_range(99) < rdy_pct);
    end
    mrd    = $urandom;
    preset = rst_en && ($urandom_range(499) == 0);
  endtask

  task automatic tick();
    sample_cycle();
    @(posedge pclk);
    #1;
    if (auto_drv) drive_auto();
  endtask

  task automatic drv(int i, bit s, bit e, bit w, logic [AW-1:0] a, logic [31:0] d);
    psel[i] = s;
    pen[i]  = e;
    pwr[i]  = w;
    padr[i] = a;
    pwd[i]  = d;
  endtask

  task automatic do_reset();
    preset = 1'b1;
    tick();
    preset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit got;
    int idle_cnt;
    for (int i = 0; i < 2; i++) begin
      drv(i, 0, 0, 0, '0, '0);
      act[i] = 0;
    end

    // Reset values.
    preset = 1'b1;
    tick();
    chk_on = 1;
    tick();
    preset = 1'b0;
    tick();
    chk("reset m_psel", s_psel, 1'b0);
    chk("reset m_penable", s_pen, 1'b0);
    chk("reset m_paddr", s_addr, '0);
    chk("reset m_pwdata", s_wd, '0);
    chk("reset m_pwrite", s_wr, 1'b0);
    chk("reset s0_pready", s_rdy[0], 1'b0);
    chk("reset s1_pslverr", s_err[1], 1'b0);

    // Single read from master 0, zero-wait slave.
    mrdy = 1'b1;
    mrd  = 32'hA5A5_0001;
    drv(0, 1, 0, 0, 11'h012, '0);
    tick();                                   // T
    chk("rd T m_psel", s_psel, 1'b0);
    drv(0, 1, 1, 0, 11'h012, '0);
    tick();                                   // T+1
    chk("rd T+1 m_psel", s_psel, 1'b1);
    chk("rd T+1 m_penable", s_pen, 1'b0);
    chk("rd T+1 m_paddr", s_addr, 11'h012);
    chk("rd T+1 s0_pready", s_rdy[0], 1'b0);
    tick();                                   // T+2
    chk("rd T+2 s0_pready", s_rdy[0], 1'b1);
    chk("rd T+2 s0_prdata", s_rd[0], 32'hA5A5_0001);
    chk("rd T+2 s0_pslverr", s_err[0], 1'b0);
    drv(0, 0, 0, 0, '0, '0);
    tick();

    // Simultaneous requests right after reset: master 0 first.
    do_reset();
    drv(0, 1, 0, 1, 11'h020, 32'h1111_0000);
    drv(1, 1, 0, 1, 11'h031, 32'h2222_0000);
    tick();                                   // T
    pen[0] = 1'b1;
    pen[1] = 1'b1;
    tick();                                   // T+1
    chk("tie T+1 m_paddr", s_addr, 11'h020);
    chk("tie T+1 m_pwdata", s_wd, 32'h1111_0000);
    tick();                                   // T+2
    chk("tie T+2 s0_pready", s_rdy[0], 1'b1);
    chk("tie T+2 s1_pready", s_rdy[1], 1'b0);
    drv(0, 0, 0, 0, '0, '0);
    tick();                                   // T+3
    chk("tie T+3 m_psel", s_psel, 1'b1);
    chk("tie T+3 m_penable", s_pen, 1'b0);
    chk("tie T+3 m_paddr", s_addr, 11'h031);
    chk("tie T+3 m_pwdata", s_wd, 32'h2222_0000);
    tick();                                   // T+4
    chk("tie T+4 s1_pready", s_rdy[1], 1'b1);
    drv(1, 0, 0, 0, '0, '0);
    tick();

    // Both masters continuously writing: grants alternate with no gap.
    do_reset();
    done_q.delete();
    req_pct  = 100;
    rdy_pct  = 100;
    stuck_en = 0;
    rst_en   = 0;
    wr_only  = 1;
    was_reset = 0;
    act[0] = 0;
    act[1] = 0;
    drive_auto();
    auto_drv = 1;
    tick();                                   // T
    idle_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();                                 // T+1 .. T+8
      if (s_psel !== 1'b1) idle_cnt++;
    end
    auto_drv = 0;
    chk("alt idle cycles", idle_cnt, 0);
    chk("alt completions", done_q.size() >= 4, 1'b1);
    if (done_q.size() >= 4) begin
      chk("alt grant 1", done_q[0], 0);
      chk("alt grant 2", done_q[1], 1);
      chk("alt grant 3", done_q[2], 0);
      chk("alt grant 4", done_q[3], 1);
    end
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 0, 0, 0, '0, '0);
    mrdy = 1'b1;
    tick();
    tick();

    // Stuck slave: error completion after TO_CYCLES access cycles.
    do_reset();
    mrdy = 1'b0;
    mrd  = 32'hDEAD_BEEF;
    drv(0, 1, 0, 0, 11'h040, '0);
    tick();                                   // T
    pen[0] = 1'b1;
    n   = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      n++;
      if (s_rdy[0] === 1'b1) got = 1;
    end
    chk("to completion seen", got, 1'b1);
    chk("to latency", n, TO_CYCLES + 1);
    chk("to s0_pslverr", s_err[0], 1'b1);
    chk("to s0_prdata", s_rd[0], 32'h0);
    drv(0, 0, 0, 0, '0, '0);
    mrdy = 1'b1;
    tick();
    drv(0, 1, 0, 0, 11'h041, '0);
    tick();
    pen[0] = 1'b1;
    tick();
    tick();
    chk("post-to s0_pready", s_rdy[0], 1'b1);
    chk("post-to s0_pslverr", s_err[0], 1'b0);
    chk("post-to s0_prdata", s_rd[0], 32'hDEAD_BEEF);
    drv(0, 0, 0, 0, '0, '0);
    tick();

    // Reset during downstream ACCESS.
    mrdy = 1'b0;
    drv(1, 1, 0, 1, 11'h055, 32'hCAFE_0055);
    tick();                                   // T
    pen[1] = 1'b1;
    tick();                                   // T+1
    tick();                                   // T+2
    preset = 1'b1;
    mrdy   = 1'b1;
    tick();                                   // T+3
    chk("rst s1_pready", s_rdy[1], 1'b0);
    chk("rst s1_pslverr", s_err[1], 1'b0);
    preset = 1'b0;
    drv(1, 0, 0, 0, '0, '0);
    tick();                                   // T+4
    chk("rst m_psel", s_psel, 1'b0);
    chk("rst m_penable", s_pen, 1'b0);
    chk("rst m_paddr", s_addr, '0);
    chk("rst m_pwdata", s_wd, '0);
    chk("rst m_pwrite", s_wr, 1'b0);
    mrd = 32'h1234_5678;
    drv(0, 1, 0, 0, 11'h056, '0);
    tick();
    pen[0] = 1'b1;
    tick();
    tick();
    chk("post-rst s0_pready", s_rdy[0], 1'b1);
    chk("post-rst s0_prdata", s_rd[0], 32'h1234_5678);
    drv(0, 0, 0, 0, '0, '0);
    tick();

    // Master 1 write with three slave wait states.
    mrdy = 1'b0;
    drv(1, 1, 0, 1, 11'h066, 32'h0BAD_F00D);
    tick();                                   // T
    pen[1] = 1'b1;
    tick();                                   // T+1
    tick();                                   // T+2
    tick();                                   // T+3
    tick();                                   // T+4
    chk("ws T+4 s1_pready", s_rdy[1], 1'b0);
    chk("ws T+4 m_paddr", s_addr, 11'h066);
    chk("ws T+4 m_pwdata", s_wd, 32'h0BAD_F00D);
    chk("ws T+4 m_pwrite", s_wr, 1'b1);
    mrdy = 1'b1;
    tick();                                   // T+5
    chk("ws T+5 s1_pready", s_rdy[1], 1'b1);
    chk("ws T+5 s1_pslverr", s_err[1], 1'b0);
    drv(1, 0, 0, 0, '0, '0);
    tick();

    // Randomized traffic, checked by the model every cycle.
    do_reset();
    req_pct  = 40;
    rdy_pct  = 70;
    stuck_en = 1;
    rst_en   = 1;
    wr_only  = 0;
    act[0]   = 0;
    act[1]   = 0;
    was_reset = 0;
    drive_auto();
    auto_drv = 1;
    for (int k = 0; k < 4000; k++) tick();
    auto_drv = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
